dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store initiator for the data BRAM: takes one load/store request from the MEM stage and issues word address,
//  byte enables and lane-shifted store data. Captures the 1-cycle-latency read word and returns it byte/half-extracted
//  and sign/zero-extended. Exactly one access is in flight at a time. The pipeline stalls on req_ready.
// PARAMETERS
//  ADDR_WIDTH  15  word-address bits driven to BRAM (32768 x 32b); upper word-address bits forced to 0
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   request accepted when req_valid&&req_ready
//  req_is_store  in   1   1=store, 0=load
//  req_funct3    in   3   RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, LSB-aligned
//  req_pc        in   32  PC of the instruction, forwarded for the BRAM store log
//  resp_valid    out  1   response present
//  resp_ready    in   1   response consumed when resp_valid&&resp_ready
//  resp_rdata    out  32  extended load data; 0 for stores
//  resp_misalign out  1   access was misaligned (see CONFIGURATION)
//  mem_w_enable  out  4   per-byte write enable to BRAM
//  mem_r_addr    out  32  BRAM read word address
//  mem_w_addr    out  32  BRAM write word address, same value as mem_r_addr
//  mem_w_data    out  32  lane-shifted store data
//  mem_row_addr  out  32  original byte address, for the log
//  mem_pc        out  32  registered req_pc
//  mem_r_data    in   32  BRAM read word, valid one cycle after the address is sampled
// BEHAVIOUR
//  - Reset values: FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misalign=0, mem_w_enable=0. All addr/data outputs=0.
//  - All outputs are registered. Reset wins over every other event in the same cycle.
//  - FSM: IDLE -> ACCESS (on accept) -> WAIT -> RESP -> IDLE (on resp_ready). req_ready=1 only in IDLE.
//  - Timing: accept at edge T. ACCESS in cycle T+1 presents address, and store w_enable for exactly this one cycle.
//    In WAIT (T+2), mem_r_data is valid and is extracted into resp_rdata. resp_valid=1 from T+3.
//  - Word address = req_addr[ADDR_WIDTH+1:2]. Address bits above that range are ignored (wrap modulo memory size).
//  - Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  - Store data: SB replicates byte0 to all lanes; SH replicates half0 to both halves; SW unchanged.
//  - Load extract: byte lane addr[1:0] or half lane addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW is the full word.
//  - resp_valid and resp_rdata hold stable while resp_ready=0. Only then does RESP exit to IDLE.
//  - No back-to-back bypass: the minimum period is 4 cycles per access when resp_ready=1.
//  - Undefined funct3: treated as LW/SW.
//  - Reset mid-operation: the FSM returns to IDLE next cycle and the response is dropped.
//    A store whose w_enable was already high in the reset cycle is still written by the BRAM.
// CONFIGURATION
//  DMEM_LSU_MISALIGN_TRAP_EN:
//   defined: misaligned access (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) still walks the FSM.
//     mem_w_enable stays 0, resp_rdata=0, and resp_misalign=1 with resp_valid.
//   undefined: low address bits are forced to alignment (half: addr[0]=0, word: addr[1:0]=0).
//     The access proceeds normally and resp_misalign is tied to 0.
// STRUCTURE
//  Shared package dmem_pkg: lsu_state_e {IDLE,ACCESS,WAIT,RESP}, funct3 localparams F3_LB..F3_SW, DMEM_ADDR_WIDTH=15.
//  Sub-module dmem_load_align: combinational (word, addr[1:0], funct3) -> extended 32b data. It is reusable by the bench model.
// TESTING
//  1 SB addr=0x1003 wdata=0x..AB -> in ACCESS: w_enable=4'b1000, w_data=0xABABABAB, w_addr=0x400, row_addr=0x1003.
//  2 mem[0x400]=0x8001_1234; LH 0x1002 -> 0xFFFF8001; LHU 0x1002 -> 0x00008001; LBU 0x1001 -> 0x00000012;
//    LB 0x1003 -> 0xFFFFFF80.
//  3 SW 0x2000 0xDEADBEEF then LW 0x2000 -> resp_rdata=0xDEADBEEF, resp_valid first at accept+3 cycles.
//  4 Hold resp_ready=0 for 3 cycles -> resp_valid/resp_rdata stable, req_ready=0, next request not accepted until handshake.
//  5 With the macro: SW 0x2002 -> w_enable never nonzero, resp_misalign=1, rdata=0.
//    Without the macro: w_enable=4'hF at word 0x800.
//  6 Assert rst during WAIT -> next cycle IDLE, req_ready=1, resp_valid=0, w_enable=0; no response emitted.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, funct3 codes and access-size decode for the data-memory LSU
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unknown funct3 codes fall back to a full-word access.
    function automatic lsu_size_e access_size(input logic is_store, input logic [2:0] f3);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (f3 == F3_SB) sz = SZ_BYTE;
            else if (f3 == F3_SH) sz = SZ_HALF;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU) sz = SZ_BYTE;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response and BRAM bus bundle between MEM stage, LSU and data BRAM
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [3:0]  mem_w_enable;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_row_addr;
    logic [31:0] mem_pc;
    logic [31:0] mem_r_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_pc,
        input  resp_ready, mem_r_data,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
        output mem_w_enable, mem_r_addr, mem_w_addr, mem_w_data, mem_row_addr, mem_pc
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_pc,
        output resp_ready, mem_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
        input  mem_w_enable, mem_r_addr, mem_w_addr, mem_w_data, mem_row_addr, mem_pc
    );
endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - picks the byte/half lane out of a BRAM word and sign/zero-extends it
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        case (funct3)
            F3_LB:   data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_LH:   data = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_LBU:  data = {24'd0, byte_sh[7:0]};
            F3_LHU:  data = {16'd0, half_sh[15:0]};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store unit for the data BRAM; DMEM_LSU_MISALIGN_TRAP_EN enables misalign reporting
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    dmem_lsu_if.slave   bus
);
    lsu_state_e  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_misalign_q, resp_misalign_d;
    logic [3:0]  w_enable_q, w_enable_d;
    logic [31:0] word_addr_q, word_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [31:0] row_addr_q, row_addr_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  lane_q, lane_d;
    logic        misalign_q, misalign_d;

    lsu_size_e   req_size;
    logic [1:0]  req_lane;
    logic [3:0]  req_enable;
    logic [31:0] req_data;
    logic        req_misalign;
    logic [31:0] load_data;

    dmem_load_align u_align (
        .word   (bus.mem_r_data),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Lane offsets are always aligned to the access size; misaligned low bits are either dropped or trapped.
    always_comb begin
        req_size = access_size(bus.req_is_store, bus.req_funct3);
        case (req_size)
            SZ_BYTE: begin
                req_lane = bus.req_addr[1:0];
                req_data = {4{bus.req_wdata[7:0]}};
                req_enable = 4'b0001 << req_lane;
            end
            SZ_HALF: begin
                req_lane = {bus.req_addr[1], 1'b0};
                req_data = {2{bus.req_wdata[15:0]}};
                req_enable = 4'b0011 << req_lane;
            end
            default: begin
                req_lane = 2'b00;
                req_data = bus.req_wdata;
                req_enable = 4'b1111;
            end
        endcase
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        case (req_size)
            SZ_BYTE: req_misalign = 1'b0;
            SZ_HALF: req_misalign = bus.req_addr[0];
            default: req_misalign = (bus.req_addr[1:0] != 2'b00);
        endcase
`else
        req_misalign = 1'b0;
`endif
        if (!bus.req_is_store || req_misalign) req_enable = 4'b0000;
    end

    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_misalign_d = resp_misalign_q;
        w_enable_d      = w_enable_q;
        word_addr_d     = word_addr_q;
        w_data_d        = w_data_q;
        row_addr_d      = row_addr_q;
        pc_d            = pc_q;
        funct3_d        = funct3_q;
        is_store_d      = is_store_q;
        lane_d          = lane_q;
        misalign_d      = misalign_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d     = ACCESS;
                req_ready_d = 1'b0;
                word_addr_d = {{(32-ADDR_WIDTH){1'b0}}, bus.req_addr[ADDR_WIDTH+1:2]};
                w_enable_d  = req_enable;
                w_data_d    = req_data;
                row_addr_d  = bus.req_addr;
                pc_d        = bus.req_pc;
                funct3_d    = bus.req_funct3;
                is_store_d  = bus.req_is_store;
                lane_d      = req_lane;
                misalign_d  = req_misalign;
            end
            ACCESS: begin
                w_enable_d = 4'b0000;
                state_d    = WAIT;
            end
            WAIT: begin
                resp_valid_d    = 1'b1;
                resp_misalign_d = misalign_q;
                resp_rdata_d    = (is_store_q || misalign_q) ? 32'd0 : load_data;
                state_d         = RESP;
            end
            default: if (bus.resp_ready) begin
                resp_valid_d    = 1'b0;
                resp_misalign_d = 1'b0;
                req_ready_d     = 1'b1;
                state_d         = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_misalign_q <= 1'b0;
            w_enable_q      <= 4'b0000;
            word_addr_q     <= 32'd0;
            w_data_q        <= 32'd0;
            row_addr_q      <= 32'd0;
            pc_q            <= 32'd0;
            funct3_q        <= 3'd0;
            is_store_q      <= 1'b0;
            lane_q          <= 2'd0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
            w_enable_q      <= w_enable_d;
            word_addr_q     <= word_addr_d;
            w_data_q        <= w_data_d;
            row_addr_q      <= row_addr_d;
            pc_q            <= pc_d;
            funct3_q        <= funct3_d;
            is_store_q      <= is_store_d;
            lane_q          <= lane_d;
            misalign_q      <= misalign_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.mem_w_enable  = w_enable_q;
    assign bus.mem_r_addr    = word_addr_q;
    assign bus.mem_w_addr    = word_addr_q;
    assign bus.mem_w_data    = w_data_q;
    assign bus.mem_row_addr  = row_addr_q;
    assign bus.mem_pc        = pc_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed and randomized checks of dmem_lsu against a behavioural memory model
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dmem_lsu_if bus ();
    dmem_lsu u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] bram    [0:32767];
    logic [31:0] ref_mem [0:32767];

    always @(posedge clk) begin
        bus.mem_r_data <= bram[bus.mem_r_addr[14:0]];
        for (int i = 0; i < 4; i++)
            if (bus.mem_w_enable[i]) bram[bus.mem_w_addr[14:0]][8*i +: 8] <= bus.mem_w_data[8*i +: 8];
    end

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int hold, output logic [31:0] got);
        int nbytes, off, idx, n;
        bit mis;
        logic [3:0]  exp_en;
        logic [31:0] exp_wd, exp_rd, w, held;
        if (st) nbytes = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        else    nbytes = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = TRAP && (off % nbytes != 0);
        off = off - (off % nbytes);
        idx = int'(addr[16:2]);
        exp_wd = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
        exp_en = (st && !mis) ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
        w = ref_mem[idx] >> (8 * off);
        if (st || mis)       exp_rd = 32'd0;
        else if (nbytes == 4) exp_rd = ref_mem[idx];
        else if (nbytes == 2) exp_rd = (f3 == 3'b001 && w[15]) ? (w | 32'hFFFF0000) : (w & 32'h0000FFFF);
        else                  exp_rd = (f3 == 3'b000 && w[7])  ? (w | 32'hFFFFFF00) : (w & 32'h000000FF);
        for (int i = 0; i < 4; i++)
            if (exp_en[i]) ref_mem[idx][8*i +: 8] = exp_wd[8*i +: 8];

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_pc = addr ^ 32'h5A5A0000;
        checks++; if (bus.req_ready !== 1'b1) fail("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_w_enable !== exp_en) fail("access_w_enable", 32'(bus.mem_w_enable), 32'(exp_en));
        checks++; if (bus.mem_r_addr !== {17'd0, addr[16:2]}) fail("access_r_addr", bus.mem_r_addr, {17'd0, addr[16:2]});
        checks++; if (bus.mem_w_addr !== {17'd0, addr[16:2]}) fail("access_w_addr", bus.mem_w_addr, {17'd0, addr[16:2]});
        checks++; if (bus.mem_row_addr !== addr) fail("access_row_addr", bus.mem_row_addr, addr);
        checks++; if (bus.mem_pc !== (addr ^ 32'h5A5A0000)) fail("access_pc", bus.mem_pc, addr ^ 32'h5A5A0000);
        if (exp_en != 4'h0) begin
            checks++; if (bus.mem_w_data !== exp_wd) fail("access_w_data", bus.mem_w_data, exp_wd);
        end
        n = 1;
        while (!bus.resp_valid && n < 10) begin
            @(negedge clk); n++;
            if (n == 2) begin
                checks++; if (bus.mem_w_enable !== 4'h0) fail("wait_w_enable_low", 32'(bus.mem_w_enable), 32'd0);
            end
        end
        checks++; if (n !== 3) fail("resp_latency", 32'(n), 32'd3);
        checks++; if (bus.resp_rdata !== exp_rd) fail("resp_rdata", bus.resp_rdata, exp_rd);
        checks++; if (bus.resp_misalign !== mis) fail("resp_misalign", 32'(bus.resp_misalign), 32'(mis));
        held = bus.resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++; if (bus.resp_valid !== 1'b1) fail("hold_valid", 32'(bus.resp_valid), 32'd1);
            checks++; if (bus.resp_rdata !== held) fail("hold_rdata", bus.resp_rdata, held);
            checks++; if (bus.req_ready !== 1'b0) fail("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        got = bus.resp_rdata;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) fail("post_resp_valid", 32'(bus.resp_valid), 32'd0);
        checks++; if (bus.req_ready !== 1'b1) fail("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] ra;
        for (int i = 0; i < 32768; i++) begin bram[i] = 32'd0; ref_mem[i] = 32'd0; end
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_pc = 32'd0; bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) fail("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checks++; if (bus.resp_valid !== 1'b0) fail("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checks++; if (bus.resp_rdata !== 32'd0) fail("rst_resp_rdata", bus.resp_rdata, 32'd0);
        checks++; if (bus.resp_misalign !== 1'b0) fail("rst_misalign", 32'(bus.resp_misalign), 32'd0);
        checks++; if (bus.mem_w_enable !== 4'h0) fail("rst_w_enable", 32'(bus.mem_w_enable), 32'd0);
        checks++; if (bus.mem_r_addr !== 32'd0) fail("rst_r_addr", bus.mem_r_addr, 32'd0);
        checks++; if (bus.mem_w_data !== 32'd0) fail("rst_w_data", bus.mem_w_data, 32'd0);

        do_access(1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB, 0, got);
        do_access(1'b1, 3'b010, 32'h0000_1000, 32'h8001_1234, 0, got);
        do_access(1'b0, 3'b001, 32'h0000_1002, 32'd0, 0, got);
        checks++; if (got !== 32'hFFFF_8001) fail("lh_0x1002", got, 32'hFFFF_8001);
        do_access(1'b0, 3'b101, 32'h0000_1002, 32'd0, 0, got);
        checks++; if (got !== 32'h0000_8001) fail("lhu_0x1002", got, 32'h0000_8001);
        do_access(1'b0, 3'b100, 32'h0000_1001, 32'd0, 0, got);
        checks++; if (got !== 32'h0000_0012) fail("lbu_0x1001", got, 32'h0000_0012);
        do_access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, got);
        checks++; if (got !== 32'hFFFF_FF80) fail("lb_0x1003", got, 32'hFFFF_FF80);
        do_access(1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 0, got);
        do_access(1'b0, 3'b010, 32'h0000_2000, 32'd0, 3, got);
        checks++; if (got !== 32'hDEAD_BEEF) fail("lw_0x2000", got, 32'hDEAD_BEEF);
        do_access(1'b1, 3'b010, 32'h0000_2002, 32'hCAFE_F00D, 1, got);
        do_access(1'b0, 3'b010, 32'h0000_2000, 32'd0, 0, got);
        checks++; if (got !== (TRAP ? 32'hDEAD_BEEF : 32'hCAFE_F00D))
            fail("lw_after_sw_0x2002", got, TRAP ? 32'hDEAD_BEEF : 32'hCAFE_F00D);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_2000;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) fail("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        checks++; if (bus.resp_valid !== 1'b0) fail("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checks++; if (bus.mem_w_enable !== 4'h0) fail("midrst_w_enable", 32'(bus.mem_w_enable), 32'd0);
        repeat (4) begin
            @(negedge clk);
            checks++; if (bus.resp_valid !== 1'b0) fail("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            ra = ($urandom & 32'hFFFE_0000) | (32'h0000_3000 + 32'($urandom_range(0, 15)) * 4)
                 | 32'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                      $urandom_range(0, 2), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
